dmem_bus_ctrl: RTL and testbench

//  Data-side bus controller directly downstream of the rv32i_core load/store port.

---
 rtl/bus_pkg.sv | 41 ++++
 rtl/dmem_bus_ctrl_if.sv | 31 +++
 rtl/dmem_bank.sv | 27 ++
 rtl/dmem_bus_ctrl.sv | 116 +++++++++++
 tb/tb_dmem_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_pkg : bus IDs, RamMode bit positions, default address map, lane extract
// Rev 1.0
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_RAM  = 2'd0,
    BUS_UART = 2'd1,
    BUS_NONE = 2'd2
  } bus_id_t;

  localparam int RM_BYTE = 3;
  localparam int RM_HALF = 2;
  localparam int RM_WORD = 1;
  localparam int RM_UNS  = 0;

  localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_0000;
  localparam int          DEF_RAM_WORDS = 1024;
  localparam logic [31:0] DEF_UART_BASE = 32'h1000_0000;
  localparam int          DEF_UART_SPAN = 16;

  // Picks the addressed lane of an aligned word and sign/zero extends it.
  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [3:0]  mode);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    if (mode[RM_BYTE])      r = {{24{b[7] & ~mode[RM_UNS]}}, b};
    else if (mode[RM_HALF]) r = {{16{h[15] & ~mode[RM_UNS]}}, h};
    else if (mode[RM_WORD]) r = word;
    else                    r = '0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bus_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_bus_ctrl_if : core load/store port plus UART register port
// Rev 1.0
// ---------------------------------------------------------------------------
interface dmem_bus_ctrl_if;
  logic [31:0] addr;
  logic [31:0] dataBusOut;
  logic        wrEn;
  logic        rdEn;
  logic [3:0]  RamMode;
  logic [31:0] dataBusIn;
  logic        dataBusInEn;
  logic        uart_wr;
  logic        uart_rd;
  logic [3:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;
  logic        bus_err;

  modport master (
    output addr, dataBusOut, wrEn, rdEn, RamMode, uart_rdata,
    input  dataBusIn, dataBusInEn, uart_wr, uart_rd, uart_addr, uart_wdata, bus_err
  );

  modport slave (
    input  addr, dataBusOut, wrEn, rdEn, RamMode, uart_rdata,
    output dataBusIn, dataBusInEn, uart_wr, uart_rd, uart_addr, uart_wdata, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_bank : WORDS x 32 synchronous RAM, byte write enables, registered read
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_bank #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  wire logic          clk,
  input  wire logic [AW-1:0] addr,
  input  wire logic [3:0]    we,
  input  wire logic [31:0]   wdata,
  output logic      [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_bus_ctrl : data-side decode to RAM/UART with fixed 2-cycle load return
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_bus_ctrl
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter int          RAM_WORDS = DEF_RAM_WORDS,
  parameter logic [31:0] UART_BASE = DEF_UART_BASE,
  parameter int          UART_SPAN = DEF_UART_SPAN
) (
  input  wire logic       clk,
  input  wire logic       rstB,
  dmem_bus_ctrl_if.slave  bus
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] ram_off;
  logic [31:0] uart_off;
  bus_id_t     region;
  logic        aligned;
  logic        access_ok;
  logic        wr_ok;
  logic        rd_ok;
  logic        fault;
  logic [3:0]  byte_en;
  logic [3:0]  ram_we;
  logic [31:0] lane_data;
  logic [31:0] ram_rdata;

  logic        s1_valid;
  logic        s1_err;
  bus_id_t     s1_region;
  logic [1:0]  s1_off;
  logic [3:0]  s1_mode;
  logic        s2_valid;
  logic [31:0] s2_data;
  logic        err_q;

  always_comb begin
    ram_off  = bus.addr - RAM_BASE;
    uart_off = bus.addr - UART_BASE;
    if (ram_off < 32'(4 * RAM_WORDS))    region = BUS_RAM;
    else if (uart_off < 32'(UART_SPAN))  region = BUS_UART;
    else                                 region = BUS_NONE;

    // An invalid RamMode falls out here as misaligned.
    aligned   = $onehot(bus.RamMode[3:1])
              && !(bus.RamMode[RM_HALF] && bus.addr[0])
              && !(bus.RamMode[RM_WORD] && (bus.addr[1:0] != 2'b00));
    access_ok = aligned && (region != BUS_NONE);
    wr_ok     = rstB && bus.wrEn && access_ok;
    rd_ok     = rstB && bus.rdEn && !bus.wrEn && access_ok;
    fault     = ((bus.rdEn || bus.wrEn) && !access_ok) || (bus.rdEn && bus.wrEn);

    if (bus.RamMode[RM_BYTE]) begin
      byte_en   = 4'b0001 << bus.addr[1:0];
      lane_data = {4{bus.dataBusOut[7:0]}};
    end else if (bus.RamMode[RM_HALF]) begin
      byte_en   = 4'b0011 << {bus.addr[1], 1'b0};
      lane_data = {2{bus.dataBusOut[15:0]}};
    end else begin
      byte_en   = 4'b1111;
      lane_data = bus.dataBusOut;
    end
    ram_we = (wr_ok && (region == BUS_RAM)) ? byte_en : 4'b0000;
  end

  dmem_bank #(.WORDS(RAM_WORDS), .AW(AW)) u_bank (
    .clk   (clk),
    .addr  (ram_off[AW+1:2]),
    .we    (ram_we),
    .wdata (lane_data),
    .rdata (ram_rdata)
  );

  assign bus.uart_wr    = wr_ok && (region == BUS_UART);
  assign bus.uart_rd    = rd_ok && (region == BUS_UART);
  assign bus.uart_addr  = bus.addr[3:0] & 4'hC;
  assign bus.uart_wdata = lane_data;

  always_ff @(posedge clk) begin
    if (!rstB) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      err_q    <= 1'b0;
    end else begin
      s1_valid <= bus.rdEn;
      s2_valid <= s1_valid;
      if (s1_valid && !s1_err)
        s2_data <= lane_extend((s1_region == BUS_UART) ? bus.uart_rdata : ram_rdata,
                               s1_off, s1_mode);
      else
        s2_data <= '0;
      if (fault) err_q <= 1'b1;
    end
  end

  // Side info only matters while s1_valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_err    <= !rd_ok;
    s1_region <= region;
    s1_off    <= bus.addr[1:0];
    s1_mode   <= bus.RamMode;
  end

  assign bus.dataBusIn   = s2_data;
  assign bus.dataBusInEn = s2_valid;
  assign bus.bus_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_bus_ctrl : directed and random load/store traffic vs. a memory/UART model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_bus_ctrl;

  logic clk  = 1'b0;
  logic rstB = 1'b0;

  dmem_bus_ctrl_if bus();

  dmem_bus_ctrl dut (
    .clk  (clk),
    .rstB (rstB),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] MB = 4'b1000;
  localparam logic [3:0] MH = 4'b0100;
  localparam logic [3:0] MW = 4'b0010;

  typedef struct {
    int          due;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          cyc    = 0;
  bit          mon_on = 1'b0;
  logic [31:0] mem [1024];
  bit          err_m  = 1'b0;
  bit          pend_v = 1'b0;
  logic [31:0] pend_d = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    if (a < 32'h0000_1000) return 0;
    if (a >= 32'h1000_0000 && a < 32'h1000_0010) return 1;
    return 2;
  endfunction

  // Load result from plain shifts and two's-complement arithmetic.
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off,
                                      input logic [3:0] mode);
    logic [31:0] v;
    if (mode[3]) begin
      v = (w >> {off, 3'b000}) & 32'hFF;
      if (!mode[0] && v >= 32'h80) v = v - 32'h100;
    end else if (mode[2]) begin
      v = (w >> {off[1], 4'b0000}) & 32'hFFFF;
      if (!mode[0] && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Scoreboard monitor: every strobe must match the oldest outstanding load.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (bus.dataBusInEn !== 1'b0) begin
        if (sbq.size() == 0) begin
          check("unexpected_strobe", {31'd0, bus.dataBusInEn}, 32'd0);
        end else begin
          e = sbq.pop_front();
          check({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
          check(e.tag, bus.dataBusIn, e.data);
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        check({e.tag, "_missing_strobe"}, {31'd0, bus.dataBusInEn}, 32'd1);
      end
    end
  end

  task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] mode, input logic [31:0] uv, input string tag);
    int          rg;
    bit          ok;
    bit          fault;
    bit          exp_uwr;
    bit          exp_urd;
    bit          hit;
    logic [31:0] wv;
    logic [31:0] ld;
    bus.rdEn       = rd;
    bus.wrEn       = wr;
    bus.addr       = a;
    bus.dataBusOut = d;
    bus.RamMode    = mode;
    bus.uart_rdata = pend_v ? pend_d : $urandom;

    rg    = region(a);
    ok    = ($countones(mode[3:1]) == 1) && !(mode[2] && a[0])
            && !(mode[1] && a[1:0] != 2'b00) && (rg != 2);
    fault = ((rd || wr) && !ok) || (rd && wr);
    if (!rstB) begin
      ok    = 1'b0;
      fault = 1'b0;
    end
    exp_uwr = wr && ok && (rg == 1);
    exp_urd = rd && !wr && ok && (rg == 1);
    pend_v  = exp_urd;
    pend_d  = uv;
    wv = mode[3] ? d[7:0] * 32'h0101_0101 : (mode[2] ? d[15:0] * 32'h0001_0001 : d);

    if (rd && rstB) begin
      ld = (ok && !wr) ? ext((rg == 1) ? uv : mem[a[11:2]], a[1:0], mode) : 32'd0;
      sbq.push_back('{cyc + 2, ld, tag});
    end
    if (wr && ok && rg == 0) begin
      for (int k = 0; k < 4; k++) begin
        hit = mode[3] ? (k == int'(a[1:0])) : (mode[2] ? ((k / 2) == int'(a[1])) : 1'b1);
        if (hit) mem[a[11:2]][8*k +: 8] = wv[8*k +: 8];
      end
    end

    @(negedge clk);
    check({tag, "_uart_wr"}, {31'd0, bus.uart_wr}, {31'd0, exp_uwr});
    check({tag, "_uart_rd"}, {31'd0, bus.uart_rd}, {31'd0, exp_urd});
    if (exp_uwr) begin
      check({tag, "_uart_addr"}, {28'd0, bus.uart_addr}, {28'd0, a[3:0] & 4'hC});
      check({tag, "_uart_wdata"}, bus.uart_wdata, wv);
    end
    check({tag, "_bus_err"}, {31'd0, bus.bus_err}, {31'd0, err_m});
    err_m = err_m | fault;
    if (!rstB) begin
      err_m  = 1'b0;
      pend_v = 1'b0;
      while (sbq.size() > 0 && sbq[sbq.size()-1].due > cyc) sbq.pop_back();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 32'd0, 32'd0, MW, 32'd0, "idle");
  endtask

  task automatic pulse_reset();
    rstB = 1'b0;
    idle();
    rstB = 1'b1;
  endtask

  initial begin
    bus.rdEn = 1'b0; bus.wrEn = 1'b0; bus.addr = '0; bus.dataBusOut = '0;
    bus.RamMode = MW; bus.uart_rdata = '0;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    idle();
    rstB = 1'b1;
    check("reset_strobe", {31'd0, bus.dataBusInEn}, 32'd0);
    check("reset_data", bus.dataBusIn, 32'd0);
    check("reset_err", {31'd0, bus.bus_err}, 32'd0);

    for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 32'(i * 4), $urandom, MW, 32'd0, "init_sw");
    op(1'b0, 1'b1, 32'hFFC, $urandom, MW, 32'd0, "init_sw_top");

    op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, MW, 32'd0, "t1_sw");
    op(1'b1, 1'b0, 32'h10, 32'd0, MW, 32'd0, "t1_lw");

    op(1'b0, 1'b1, 32'h13, 32'h80, MB, 32'd0, "t2_sb");
    op(1'b1, 1'b0, 32'h13, 32'd0, MB, 32'd0, "t2_lb");
    op(1'b1, 1'b0, 32'h13, 32'd0, MB | 4'b0001, 32'd0, "t2_lbu");
    op(1'b1, 1'b0, 32'h12, 32'd0, MH | 4'b0001, 32'd0, "t2_lhu");
    op(1'b1, 1'b0, 32'h10, 32'd0, MH, 32'd0, "t2_lh_low");

    op(1'b1, 1'b0, 32'h0, 32'd0, MW, 32'd0, "t3_lw0");
    op(1'b1, 1'b0, 32'h4, 32'd0, MW, 32'd0, "t3_lw4");
    op(1'b1, 1'b0, 32'h8, 32'd0, MW, 32'd0, "t3_lw8");

    op(1'b0, 1'b1, 32'h1000_0004, 32'h41, MW, 32'd0, "t5_uart_sw");
    op(1'b1, 1'b0, 32'h1000_0008, 32'd0, MW, 32'h5, "t5_uart_lw");
    op(1'b0, 1'b1, 32'h1000_000E, 32'h1234_5678, MH, 32'd0, "t5_uart_sh");
    op(1'b1, 1'b0, 32'hFFC, 32'd0, MW, 32'd0, "edge_ram_top");
    idle();

    op(1'b1, 1'b0, 32'h11, 32'd0, MW, 32'd0, "t4_lw_misaligned");
    op(1'b0, 1'b1, 32'h11, 32'hFFFF_FFFF, MH, 32'd0, "t4_sh_misaligned");
    op(1'b1, 1'b0, 32'h1000, 32'd0, MW, 32'd0, "edge_unmapped");
    op(1'b0, 1'b1, 32'h1000_0010, 32'h1, MW, 32'd0, "edge_uart_end");
    op(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, MW, 32'd0, "rdwr_both");
    op(1'b1, 1'b0, 32'h20, 32'd0, 4'b1010, 32'd0, "bad_mode");
    repeat (3) idle();

    op(1'b1, 1'b0, 32'h10, 32'd0, MW, 32'd0, "t6_lw_dropped");
    pulse_reset();
    idle();
    check("t6_post_strobe", {31'd0, bus.dataBusInEn}, 32'd0);
    check("t6_post_data", bus.dataBusIn, 32'd0);
    check("t6_post_err", {31'd0, bus.bus_err}, 32'd0);
    op(1'b1, 1'b0, 32'h10, 32'd0, MW, 32'd0, "t6_lw_kept");
    op(1'b1, 1'b0, 32'h20, 32'd0, MW, 32'd0, "t6_lw_rdwr_store");

    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      logic [3:0]  m;
      int          p;
      bit          rd;
      bit          wr;
      if ($urandom_range(0, 99) < 2) begin
        pulse_reset();
        continue;
      end
      case ($urandom_range(0, 2))
        0:       m = MB;
        1:       m = MH;
        default: m = MW;
      endcase
      m[0] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) m = 4'($urandom);
      p = int'($urandom_range(0, 99));
      if (p < 75)      a = 32'($urandom_range(0, 255));
      else if (p < 88) a = 32'h1000_0000 + 32'($urandom_range(0, 15));
      else if (p < 94) a = 32'hFFC + 32'($urandom_range(0, 7));
      else             a = 32'h2000_0000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) != 0) begin
        if (m[2]) a[0] = 1'b0;
        if (m[1]) a[1:0] = 2'b00;
      end
      p  = int'($urandom_range(0, 99));
      rd = (p < 45) || (p >= 97);
      wr = (p >= 45 && p < 88) || (p >= 97);
      op(rd, wr, a, $urandom, m, $urandom, "rand");
    end

    repeat (4) idle();
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
